// File: rtl/jtcontra_rom_pkg.sv
`default_nettype none
// ============================================================================
// jtcontra_rom_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the Contra ROM arbiter.
//   - Arbiter FSM state encoding (state_t)
//   - Slot count and slot index constants
//   - Default SDRAM word offsets for each slot
//   - rr_pick: round-robin selector used by the arbiter
// Revision: 1.0 - initial release
// ============================================================================
package jtcontra_rom_pkg;

  localparam int NSLOT = 4;

  localparam logic [1:0] SLOT_MAIN = 2'd0;
  localparam logic [1:0] SLOT_SND  = 2'd1;
  localparam logic [1:0] SLOT_GFX1 = 2'd2;
  localparam logic [1:0] SLOT_GFX2 = 2'd3;

  localparam logic [21:0] DEF_SLOT0_OFFSET = 22'h00_0000;
  localparam logic [21:0] DEF_SLOT1_OFFSET = 22'h01_0000;
  localparam logic [21:0] DEF_SLOT2_OFFSET = 22'h02_0000;
  localparam logic [21:0] DEF_SLOT3_OFFSET = 22'h08_0000;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_WAIT_RDY = 2'd2
  } state_t;

  // First requesting slot found when searching upward (with wrap) from the
  // slot just after 'last'. Returns 'last' when nothing requests.
  function automatic logic [1:0] rr_pick(input logic [NSLOT-1:0] req,
                                         input logic [1:0]       last);
    logic [1:0] idx;
    logic       found;
    rr_pick = last;
    found   = 1'b0;
    for (int i = 1; i <= NSLOT; i++) begin
      idx = last + 2'(i);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/jtcontra_rom_slot.sv
`default_nettype none
// ============================================================================
// jtcontra_rom_slot
// ----------------------------------------------------------------------------
// One-word (16-bit) read cache for a single ROM requester.
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   cs, addr         requester chip select and byte address
//   fill             write the cache this cycle
//   fill_tag         word address that the fill data belongs to
//   fill_data        16-bit word from SDRAM
//   ok               cached word matches the current address (combinational)
//   dout             selected byte of the cached word (always driven)
//   miss             requester is selected but the cache does not match
// Revision: 1.0 - initial release
// ============================================================================
module jtcontra_rom_slot #(
  parameter int AW = 17
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  input  logic          fill,
  input  logic [AW-2:0] fill_tag,
  input  logic [15:0]   fill_data,
  output logic          ok,
  output logic [7:0]    dout,
  output logic          miss
);

  logic          valid;
  logic [AW-2:0] tag;
  logic [15:0]   word;

  // ROM is read-only: the entry is only ever replaced, never invalidated.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid <= 1'b0;
      tag   <= '0;
      word  <= '0;
    end else if (fill) begin
      valid <= 1'b1;
      tag   <= fill_tag;
      word  <= fill_data;
    end
  end

  assign ok   = cs && valid && (tag == addr[AW-1:1]);
  assign dout = addr[0] ? word[15:8] : word[7:0];
  assign miss = cs && !ok;

endmodule
`default_nettype wire

// File: rtl/jtcontra_rom_arb.sv
`default_nettype none
// ============================================================================
// jtcontra_rom_arb
// ----------------------------------------------------------------------------
// Shares the SDRAM read port among four ROM requesters, each fronted by a
// one-word cache (slot 0 main CPU, 1 sound CPU, 2 gfx1, 3 gfx2).
// Ports:
//   clk, rstn       48 MHz clock, asynchronous active-low reset
//   slot_cs[3:0]    per-slot request
//   slot_addr       per-slot byte address, slot n at [n*AW +: AW]
//   slot_dout       per-slot byte, slot n at [n*8 +: 8]
//   slot_ok[3:0]    per-slot data valid for the current address
//   sdram_req       read request, held until sdram_ack
//   sdram_addr      SDRAM word address (offset + word address)
//   sdram_ack       request accepted (pulse)
//   sdram_rdy       read data valid (pulse)
//   sdram_data      read data word
// Build option:
//   JTCONTRA_ROMARB_PRIO_EN  slot 0 always wins; slots 1..3 round-robin.
//   (undefined)              round-robin across all four slots.
// Revision: 1.0 - initial release
// ============================================================================
module jtcontra_rom_arb
  import jtcontra_rom_pkg::*;
#(
  parameter int          AW           = 17,
  parameter logic [21:0] SLOT0_OFFSET = DEF_SLOT0_OFFSET,
  parameter logic [21:0] SLOT1_OFFSET = DEF_SLOT1_OFFSET,
  parameter logic [21:0] SLOT2_OFFSET = DEF_SLOT2_OFFSET,
  parameter logic [21:0] SLOT3_OFFSET = DEF_SLOT3_OFFSET
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [NSLOT-1:0]    slot_cs,
  input  logic [NSLOT*AW-1:0] slot_addr,
  output logic [NSLOT*8-1:0]  slot_dout,
  output logic [NSLOT-1:0]    slot_ok,
  output logic                sdram_req,
  output logic [21:0]         sdram_addr,
  input  logic                sdram_ack,
  input  logic                sdram_rdy,
  input  logic [15:0]         sdram_data
);

  localparam logic [21:0] OFFSET [NSLOT] = '{SLOT0_OFFSET, SLOT1_OFFSET,
                                             SLOT2_OFFSET, SLOT3_OFFSET};

  state_t        state, state_nx;
  logic [1:0]    last;       // last granted slot
  logic [1:0]    gnt_slot;   // slot owning the outstanding fetch
  logic [AW-2:0] gnt_tag;    // word address latched at grant
  logic [1:0]    pick;
  logic [AW-2:0] pick_wa;
  logic [21:0]   pick_addr;
  logic          fill;
  logic          grant;

  logic [NSLOT-1:0] miss;
  logic [AW-2:0]    wa [NSLOT];

  generate
    for (genvar n = 0; n < NSLOT; n++) begin : g_slot
      assign wa[n] = slot_addr[n*AW+1 +: AW-1];

      jtcontra_rom_slot #(.AW(AW)) u_slot (
        .clk       (clk),
        .rstn      (rstn),
        .cs        (slot_cs[n]),
        .addr      (slot_addr[n*AW +: AW]),
        .fill      (fill && (gnt_slot == 2'(n))),
        .fill_tag  (gnt_tag),
        .fill_data (sdram_data),
        .ok        (slot_ok[n]),
        .dout      (slot_dout[n*8 +: 8]),
        .miss      (miss[n])
      );
    end
  endgenerate

  // Grant selection
  always_comb begin
`ifdef JTCONTRA_ROMARB_PRIO_EN
    if (miss[SLOT_MAIN]) begin
      pick = SLOT_MAIN;
    end else begin
      // Slot 0 is masked out so the rotation only spans slots 1..3.
      pick = rr_pick(miss & 4'b1110, last);
    end
`else
    pick = rr_pick(miss, last);
`endif
    pick_wa   = wa[pick];
    pick_addr = OFFSET[pick] + 22'(pick_wa);
  end

  assign grant     = (state == ST_IDLE) && (|miss);
  assign sdram_req = (state == ST_WAIT_ACK);

  // Next state / fill strobe
  always_comb begin
    state_nx = state;
    fill     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|miss) state_nx = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (sdram_ack) begin
          // ack and rdy together: accept both, fill immediately.
          if (sdram_rdy) begin
            fill     = 1'b1;
            state_nx = ST_IDLE;
          end else begin
            state_nx = ST_WAIT_RDY;
          end
        end
      end
      ST_WAIT_RDY: begin
        if (sdram_rdy) begin
          fill     = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      last       <= SLOT_GFX2;
      gnt_slot   <= SLOT_MAIN;
      gnt_tag    <= '0;
      sdram_addr <= '0;
    end else begin
      state <= state_nx;
      if (grant) begin
        last       <= pick;
        gnt_slot   <= pick;
        gnt_tag    <= pick_wa;
        sdram_addr <= pick_addr;
      end
    end
  end

endmodule
`default_nettype wire
